// File: rtl/axi4_wr_burst_master.sv
// AXI4 write burst master: takes one command (address, beats-1), issues a single INCR burst and reports the B response.
// Optional B-response watchdog is enabled by defining AXI4_WR_BURST_TIMEOUT_EN.
module axi4_wr_burst_master #(
    parameter int                  DWIDTH         = 512,
    parameter int                  AWIDTH         = 32,
    parameter int                  IDWIDTH        = 4,
    parameter logic [IDWIDTH-1:0]  AWID_VAL       = '0,
    parameter int                  TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [AWIDTH-1:0]     i_cmd_addr,
    input  logic [7:0]            i_cmd_len,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [DWIDTH-1:0]     i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic                  o_done_valid,
    output logic [1:0]            o_done_resp,
    output logic                  o_done_tout,
    output logic [IDWIDTH-1:0]    o_awid,
    output logic [AWIDTH-1:0]     o_awaddr,
    output logic [7:0]            o_awlen,
    output logic [2:0]            o_awsize,
    output logic [1:0]            o_awburst,
    output logic [2:0]            o_awprot,
    output logic [3:0]            o_awcache,
    output logic [3:0]            o_awuser,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [DWIDTH-1:0]     o_wdata,
    output logic [DWIDTH/8-1:0]   o_wstrb,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // ADDR  | presenting the AW request until awready
    // DATA  | passing payload beats from s_* to W
    // RESP  | waiting for the B response (or watchdog expiry)
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    localparam int         STRBW  = DWIDTH / 8;
    localparam logic [2:0] AWSIZE = 3'($clog2(STRBW));

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_addr;
    logic [7:0]          r_len;
    logic [7:0]          r_beat;
    logic                r_done_valid;
    logic [1:0]          r_done_resp;
    logic                w_accept;
    logic                w_w_hs;
    logic                w_last_hs;
    logic                w_b_hs;
    logic                w_tout_fire;

    assign w_accept  = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_w_hs    = o_wvalid && i_wready;
    assign w_last_hs = w_w_hs && o_wlast;
    assign w_b_hs    = (r_state == ST_RESP) && i_bvalid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_cmd_valid)              w_state_nxt = ST_ADDR;
            ST_ADDR: if (i_awready)                w_state_nxt = ST_DATA;
            ST_DATA: if (w_last_hs)                w_state_nxt = ST_RESP;
            ST_RESP: if (i_bvalid || w_tout_fire)  w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    // Constant AW fields are only driven while awvalid is up, so every output except cmd_ready reads 0 out of reset.
    always_comb begin
        o_cmd_ready = 1'b0;
        o_awvalid   = 1'b0;
        o_awid      = '0;
        o_awsize    = 3'b000;
        o_awburst   = 2'b00;
        o_awprot    = 3'b000;
        o_awcache   = 4'b0000;
        o_awuser    = 4'b0000;
        o_wvalid    = 1'b0;
        o_s_ready   = 1'b0;
        o_wdata     = '0;
        o_wstrb     = '0;
        o_wlast     = 1'b0;
        o_bready    = 1'b0;
        case (r_state)
            ST_IDLE: o_cmd_ready = 1'b1;
            ST_ADDR: begin
                o_awvalid = 1'b1;
                o_awid    = AWID_VAL;
                o_awsize  = AWSIZE;
                o_awburst = 2'b01;
                o_awcache = 4'b0011;
            end
            ST_DATA: begin
                o_wvalid  = i_s_valid;
                o_s_ready = i_wready;
                o_wdata   = i_s_data;
                o_wstrb   = {STRBW{1'b1}};
                o_wlast   = (r_beat == r_len);
            end
            ST_RESP: o_bready = 1'b1;
            default: ;
        endcase
    end

    assign o_awaddr = r_addr;
    assign o_awlen  = r_len;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_len  <= '0;
            r_beat <= '0;
        end else if (w_accept) begin
            r_addr <= i_cmd_addr;
            r_len  <= i_cmd_len;
            r_beat <= '0;
        end else if (w_w_hs) begin
            r_beat <= r_beat + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done_valid <= 1'b0;
            r_done_resp  <= 2'b00;
        end else begin
            r_done_valid <= w_b_hs || w_tout_fire;
            r_done_resp  <= w_b_hs ? i_bresp : (w_tout_fire ? 2'b10 : 2'b00);
        end
    end

    assign o_done_valid = r_done_valid;
    assign o_done_resp  = r_done_resp;

`ifdef AXI4_WR_BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmr;
    logic          r_done_tout;

    // Down-counter loaded as RESP is entered; terminal count on the last allowed RESP cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmr <= '0;
        end else if ((r_state == ST_DATA) && w_last_hs) begin
            r_tmr <= TW'(TIMEOUT_CYCLES - 1);
        end else if ((r_state == ST_RESP) && (r_tmr != '0)) begin
            r_tmr <= r_tmr - TW'(1);
        end
    end

    assign w_tout_fire = (r_state == ST_RESP) && !i_bvalid && (r_tmr == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done_tout <= 1'b0;
        end else begin
            r_done_tout <= w_tout_fire;
        end
    end

    assign o_done_tout = r_done_tout;
`else
    logic w_unused_tout_cfg;

    assign w_unused_tout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_tout_fire       = 1'b0;
    assign o_done_tout       = 1'b0;
`endif

endmodule

// File: doc/axi4_wr_burst_master.md
AXI4_WR_BURST_MASTER -- requirements
Module: axi4_wr_burst_master

Interface
REQ-001 SHALL have parameter DWIDTH, default 512, data width in bits (power of two, >=8).
REQ-002 SHALL have parameter AWIDTH, default 32, address width.
REQ-003 SHALL have parameter IDWIDTH, default 4, AXI ID width; AWID_VAL, default 0, constant awid.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, B-response watchdog limit.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cmd_addr  in  AWIDTH  burst start byte address, DWIDTH/8-aligned.
REQ-008 cmd_len  in  8  beats minus one (0..255).
REQ-009 cmd_valid / cmd_ready  in / out  1  command handshake.
REQ-010 s_data  in  DWIDTH  write payload; s_valid / s_ready  in / out  1  payload handshake.
REQ-011 done_valid  out  1  one-cycle pulse at burst completion; done_resp  out  2  final response; done_tout  out  1  timeout flag.
REQ-012 AW channel out: awid IDWIDTH, awaddr AWIDTH, awlen 8, awsize 3, awburst 2, awprot 3, awcache 4, awuser 4, awvalid 1; in: awready 1.
REQ-013 W channel out: wdata DWIDTH, wstrb DWIDTH/8, wlast 1, wvalid 1; in: wready 1.
REQ-014 B channel in: bresp 2, bvalid 1; out: bready 1.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA, RESP.
REQ-016 IDLE: cmd_ready=1; on cmd_valid, SHALL latch cmd_addr/cmd_len, clear beat counter, go to ADDR.
REQ-017 ADDR: awvalid=1 (first cycle after accept), fields held stable until awready; on awvalid&awready go to DATA.
REQ-018 Constant AW fields: awid=AWID_VAL, awsize=log2(DWIDTH/8) (6 at 512), awburst=2'b01, awcache=4'b0011, awprot=0, awuser=0.
REQ-019 DATA: wvalid=s_valid, s_ready=wready, wdata=s_data, wstrb all ones; all three combinational pass-through in DATA only, else wvalid=0, s_ready=0.
REQ-020 Beat counter (8 bit) SHALL increment on wvalid&wready; wlast=1 when counter equals latched cmd_len.
REQ-021 On wvalid&wready&wlast SHALL go to RESP; cmd_len=0 yields single beat with wlast on first beat.
REQ-022 RESP: bready=1; on bvalid SHALL pulse done_valid next cycle with done_resp=bresp, done_tout=0, return to IDLE.
REQ-023 cmd_ready SHALL be 0 in every state except IDLE; no W beat before AW handshake.
REQ-024 bvalid outside RESP SHALL be ignored (bready=0).
REQ-025 Minimum command-accept-to-done latency: 1+1+(cmd_len+1)+1 cycles with zero-wait slave.

Reset
REQ-026 rst SHALL force IDLE, counters 0, latched command 0, and all outputs 0 except cmd_ready=1 on the cycle after rst is sampled.
REQ-027 rst mid-burst SHALL abandon the burst without wlast or done_valid; slave-side cleanup is the system's responsibility.

Configuration
REQ-028 Macro AXI4_WR_BURST_TIMEOUT_EN defined: RESP cycle counter, cleared on RESP entry; at TIMEOUT_CYCLES cycles without bvalid SHALL pulse done_valid with done_resp=2'b10, done_tout=1, return to IDLE.
REQ-029 Macro undefined: no counter logic, RESP waits indefinitely, done_tout tied 0.

Verification
REQ-030 cmd_addr=0x1000, cmd_len=3, zero-wait slave, bresp=0 -> one AW with awlen=3, awsize=6, 4 W beats, wlast on beat 4 only, done_valid with done_resp=0 at cycle 7 after accept.
REQ-031 cmd_len=0 -> single beat with wlast=1, awlen=0.
REQ-032 awready delayed 5 cycles, wready toggled every other cycle, s_valid gaps -> awaddr/awlen stable, exactly cmd_len+1 beats, data order preserved.
REQ-033 bresp=2'b10 -> done_resp=2'b10, done_tout=0; cmd_valid held during burst -> second command accepted only after done_valid.
REQ-034 With AXI4_WR_BURST_TIMEOUT_EN, TIMEOUT_CYCLES=16, bvalid never asserted -> done_valid after 16 RESP cycles, done_resp=2'b10, done_tout=1.
REQ-035 rst asserted on beat 2 of cmd_len=7 -> next cycle awvalid=wvalid=bready=0, cmd_ready=1, no done_valid.
